// File: rtl/program_counter_ctrl.sv
// program_counter_ctrl
// Program counter and fetch sequencer for the single-cycle datapath.
// Holds the instruction address, advances it every RUN cycle, and redirects
// it on a taken branch steered by the ALU's registered condition flag.
// Start/Halt sequence the IDLE -> RUN -> DONE lifecycle.
//
// Optional feature: define PC_CYCLE_COUNT_EN to add the 16-bit saturating
// CycleCount output that counts RUN cycles since the last accepted Start.
module program_counter_ctrl #(
  parameter int W          = 10,
  parameter int START_ADDR = 0
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic         Halt,
  input  logic         Stall,
  input  logic         BranchEn,
  input  logic         BranchRel,
  input  logic [W-1:0] Target,
  input  logic         Cond,
  output logic [W-1:0] ProgCtr,
  output logic         Running,
  output logic         Done
`ifdef PC_CYCLE_COUNT_EN
  ,
  output logic [15:0]  CycleCount
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [W-1:0] START_PC = W'(START_ADDR);
  localparam logic [W-1:0] PC_ONE   = {{(W-1){1'b0}}, 1'b1};

  state_t         state_r;
  state_t         state_s;
  logic [W-1:0]   pc_r;
  logic [W-1:0]   pc_s;
  logic           running_r;
  logic           done_r;

  // Next-state and next-PC selection; Stall > Halt > taken branch > increment.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    case (state_r)
      IDLE: begin
        pc_s = START_PC;
        if (Start) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (Stall) begin
          pc_s = pc_r;
        end else if (Halt) begin
          // Stop with the PC parked on the halt instruction.
          state_s = DONE;
          pc_s    = pc_r;
        end else if (BranchEn && Cond) begin
          if (BranchRel) begin
            // Modulo-2^W add: a two's-complement offset wraps naturally.
            pc_s = pc_r + Target;
          end else begin
            pc_s = Target;
          end
        end else begin
          pc_s = pc_r + PC_ONE;
        end
      end
      DONE: begin
        if (Start) begin
          state_s = RUN;
          pc_s    = START_PC;
        end else begin
          state_s = DONE;
          pc_s    = pc_r;
        end
      end
      default: begin
        state_s = IDLE;
        pc_s    = START_PC;
      end
    endcase
  end

  // State, PC and registered state decodes; async reset returns to IDLE.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r   <= IDLE;
      pc_r      <= START_PC;
      running_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      pc_r      <= pc_s;
      running_r <= (state_s == RUN);
      done_r    <= (state_s == DONE);
    end
  end

  assign ProgCtr = pc_r;
  assign Running = running_r;
  assign Done    = done_r;

`ifdef PC_CYCLE_COUNT_EN
  logic        start_accept_s;
  logic [15:0] cnt_r;
  logic [15:0] cnt_s;

  // Cycle counter next value: clear on accepted Start, saturating count in RUN.
  always_comb begin
    cnt_s          = cnt_r;
    start_accept_s = Start && ((state_r == IDLE) || (state_r == DONE));
    if (start_accept_s) begin
      cnt_s = 16'h0000;
    end else if ((state_r == RUN) && (cnt_r != 16'hFFFF)) begin
      cnt_s = cnt_r + 16'h0001;
    end else begin
      cnt_s = cnt_r;
    end
  end

  // Cycle counter register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_r <= 16'h0000;
    end else begin
      cnt_r <= cnt_s;
    end
  end

  assign CycleCount = cnt_r;
`endif

endmodule

// File: tb/tb_program_counter_ctrl.sv
// Self-checking bench for program_counter_ctrl (W = 10, START_ADDR = 0).
// Each task queues stimulus rows with hand-derived expected PC/state values,
// then replays them one clock at a time and checks each scoreboard entry.
module tb_program_counter_ctrl;

  localparam int W = 10;

  logic         Clk;
  logic         Reset;
  logic         Start;
  logic         Halt;
  logic         Stall;
  logic         BranchEn;
  logic         BranchRel;
  logic [W-1:0] Target;
  logic         Cond;
  logic [W-1:0] ProgCtr;
  logic         Running;
  logic         Done;
`ifdef PC_CYCLE_COUNT_EN
  logic [15:0]  CycleCount;
`endif

  program_counter_ctrl #(.W(W), .START_ADDR(0)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Halt      (Halt),
    .Stall     (Stall),
    .BranchEn  (BranchEn),
    .BranchRel (BranchRel),
    .Target    (Target),
    .Cond      (Cond),
    .ProgCtr   (ProgCtr),
    .Running   (Running),
    .Done      (Done)
`ifdef PC_CYCLE_COUNT_EN
    ,
    .CycleCount(CycleCount)
`endif
  );

  typedef struct {
    logic         start;
    logic         halt;
    logic         stall;
    logic         ben;
    logic         brel;
    logic [W-1:0] tgt;
    logic         cond;
  } stim_t;

  typedef struct {
    logic [W-1:0] pc;
    logic         run;
    logic         done;
  } exp_t;

  stim_t st_q[$];
  exp_t  sb[$];
  int    checks   = 0;
  int    failures = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Queue one stimulus row and the outputs expected after the next edge.
  task automatic add(input logic start, input logic halt, input logic stall,
                     input logic ben, input logic brel, input logic [W-1:0] tgt,
                     input logic cond, input logic [W-1:0] pc,
                     input logic run, input logic done);
    stim_t s;
    exp_t  e;
    s.start = start; s.halt = halt; s.stall = stall; s.ben = ben;
    s.brel = brel; s.tgt = tgt; s.cond = cond;
    e.pc = pc; e.run = run; e.done = done;
    st_q.push_back(s);
    sb.push_back(e);
  endtask

  task automatic drive(input stim_t s);
    Start = s.start; Halt = s.halt; Stall = s.stall; BranchEn = s.ben;
    BranchRel = s.brel; Target = s.tgt; Cond = s.cond;
  endtask

  task automatic test_reset();
    exp_t e;
    Reset = 1'b1;
    drive('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0});
    sb.push_back('{10'h000, 1'b0, 1'b0});
    #2;
    e = sb.pop_front();
    checks++;
    if ({ProgCtr, Running, Done} !== {e.pc, e.run, e.done}) begin
      failures++;
      $display("FAIL reset: got pc=%h run=%b done=%b, expected pc=%h run=%b done=%b",
               ProgCtr, Running, Done, e.pc, e.run, e.done);
    end
    @(posedge Clk); #1;
    Reset = 1'b0;
  endtask

  task automatic test_seq_halt();
    stim_t s;
    exp_t  e;
    add(0,0,0,0,0,10'h000,0, 10'h000,0,0);   // IDLE holds START_ADDR
    add(1,0,0,0,0,10'h000,0, 10'h000,1,0);   // Start: RUN, PC stays 0
    add(0,0,0,0,0,10'h000,0, 10'h001,1,0);
    add(0,0,0,0,0,10'h000,0, 10'h002,1,0);
    add(0,0,0,0,0,10'h000,0, 10'h003,1,0);
    add(0,0,0,0,0,10'h000,0, 10'h004,1,0);
    add(0,0,0,0,0,10'h000,0, 10'h005,1,0);
    add(0,1,0,0,0,10'h000,0, 10'h005,0,1);   // Halt at 5
    add(0,0,0,1,0,10'h100,1, 10'h005,0,1);   // DONE ignores branch
    for (int i = 0; st_q.size() > 0; i++) begin
      s = st_q.pop_front();
      drive(s);
      @(posedge Clk); #1;
      e = sb.pop_front();
      checks++;
      if ({ProgCtr, Running, Done} !== {e.pc, e.run, e.done}) begin
        failures++;
        $display("FAIL seq_halt[%0d]: got pc=%h run=%b done=%b, expected pc=%h run=%b done=%b",
                 i, ProgCtr, Running, Done, e.pc, e.run, e.done);
      end
    end
  endtask

  task automatic test_branch();
    stim_t s;
    exp_t  e;
    add(1,0,0,0,0,10'h000,0, 10'h000,1,0);   // restart from DONE
    add(0,0,0,0,0,10'h000,0, 10'h001,1,0);
    add(0,0,0,0,0,10'h000,0, 10'h002,1,0);
    add(0,0,0,0,0,10'h000,0, 10'h003,1,0);
    add(0,0,0,1,1,10'h3FE,1, 10'h001,1,0);   // rel -2 taken
    add(0,0,0,0,0,10'h000,0, 10'h002,1,0);
    add(0,0,0,0,0,10'h000,0, 10'h003,1,0);
    add(0,0,0,1,1,10'h3FE,0, 10'h004,1,0);   // rel -2 not taken
    add(0,0,0,0,0,10'h000,0, 10'h005,1,0);
    add(0,0,0,0,0,10'h000,0, 10'h006,1,0);
    add(0,0,0,0,0,10'h000,0, 10'h007,1,0);
    add(0,0,0,1,0,10'h200,1, 10'h200,1,0);   // absolute
    add(0,0,0,1,0,10'h3FF,1, 10'h3FF,1,0);
    add(0,0,0,0,0,10'h000,0, 10'h000,1,0);   // wrap 3FF -> 0
    add(0,0,0,0,0,10'h3FF,1, 10'h001,1,0);   // Cond without BranchEn
    add(0,0,0,1,1,10'h000,1, 10'h001,1,0);   // self-loop
    add(0,1,0,1,0,10'h200,1, 10'h001,0,1);   // Halt beats branch
    for (int i = 0; st_q.size() > 0; i++) begin
      s = st_q.pop_front();
      drive(s);
      @(posedge Clk); #1;
      e = sb.pop_front();
      checks++;
      if ({ProgCtr, Running, Done} !== {e.pc, e.run, e.done}) begin
        failures++;
        $display("FAIL branch[%0d]: got pc=%h run=%b done=%b, expected pc=%h run=%b done=%b",
                 i, ProgCtr, Running, Done, e.pc, e.run, e.done);
      end
    end
  endtask

  task automatic test_stall();
    stim_t s;
    exp_t  e;
    add(1,0,0,0,0,10'h000,0, 10'h000,1,0);
    add(0,0,0,0,0,10'h000,0, 10'h001,1,0);
    add(1,0,0,0,0,10'h000,0, 10'h002,1,0);   // Start ignored in RUN
    add(0,0,0,0,0,10'h000,0, 10'h003,1,0);
    add(0,0,0,0,0,10'h000,0, 10'h004,1,0);
    add(0,1,1,1,0,10'h100,1, 10'h004,1,0);   // stall beats halt/branch
    add(0,1,1,1,0,10'h100,1, 10'h004,1,0);
    add(0,1,1,1,0,10'h100,1, 10'h004,1,0);
    add(0,1,0,0,0,10'h000,0, 10'h004,0,1);   // stall drops: halt
    for (int i = 0; st_q.size() > 0; i++) begin
      s = st_q.pop_front();
      drive(s);
      @(posedge Clk); #1;
      e = sb.pop_front();
      checks++;
      if ({ProgCtr, Running, Done} !== {e.pc, e.run, e.done}) begin
        failures++;
        $display("FAIL stall[%0d]: got pc=%h run=%b done=%b, expected pc=%h run=%b done=%b",
                 i, ProgCtr, Running, Done, e.pc, e.run, e.done);
      end
    end
  endtask

  task automatic test_async_reset();
    stim_t s;
    exp_t  e;
    add(1,0,0,0,0,10'h000,0, 10'h000,1,0);
    for (int k = 1; k <= 9; k++) add(0,0,0,0,0,10'h000,0, W'(k),1,0);
    for (int i = 0; st_q.size() > 0; i++) begin
      s = st_q.pop_front();
      drive(s);
      @(posedge Clk); #1;
      e = sb.pop_front();
      checks++;
      if ({ProgCtr, Running, Done} !== {e.pc, e.run, e.done}) begin
        failures++;
        $display("FAIL async_pre[%0d]: got pc=%h run=%b done=%b, expected pc=%h run=%b done=%b",
                 i, ProgCtr, Running, Done, e.pc, e.run, e.done);
      end
    end
    // Mid-cycle reset at PC 9: outputs must clear before any edge.
    sb.push_back('{10'h000, 1'b0, 1'b0});
    #2 Reset = 1'b1;
    #1;
    e = sb.pop_front();
    checks++;
    if ({ProgCtr, Running, Done} !== {e.pc, e.run, e.done}) begin
      failures++;
      $display("FAIL async_reset: got pc=%h run=%b done=%b, expected pc=%h run=%b done=%b",
               ProgCtr, Running, Done, e.pc, e.run, e.done);
    end
    @(posedge Clk); #1;
    Reset = 1'b0;
    add(0,0,0,0,0,10'h000,0, 10'h000,0,0);
    add(1,0,0,0,0,10'h000,0, 10'h000,1,0);
    add(0,0,0,0,0,10'h000,0, 10'h001,1,0);
    add(0,1,0,0,0,10'h000,0, 10'h001,0,1);
    add(1,0,0,0,0,10'h000,0, 10'h000,1,0);   // Start in DONE reloads 0
    for (int i = 0; st_q.size() > 0; i++) begin
      s = st_q.pop_front();
      drive(s);
      @(posedge Clk); #1;
      e = sb.pop_front();
      checks++;
      if ({ProgCtr, Running, Done} !== {e.pc, e.run, e.done}) begin
        failures++;
        $display("FAIL async_post[%0d]: got pc=%h run=%b done=%b, expected pc=%h run=%b done=%b",
                 i, ProgCtr, Running, Done, e.pc, e.run, e.done);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t s;
    exp_t  e;
    add(0,0,0,0,0,10'h000,0, 10'h001,1,0);
    add(0,1,0,0,0,10'h000,0, 10'h001,0,1);
    add(1,0,0,0,0,10'h000,0, 10'h000,1,0);   // Start level restarts
    add(1,0,0,0,0,10'h000,0, 10'h001,1,0);   // still high in RUN: ignored
    add(1,1,0,0,0,10'h000,0, 10'h001,0,1);
    add(1,0,0,0,0,10'h000,0, 10'h000,1,0);   // restarts again
    add(0,0,0,0,0,10'h000,0, 10'h001,1,0);
    for (int i = 0; st_q.size() > 0; i++) begin
      s = st_q.pop_front();
      drive(s);
      @(posedge Clk); #1;
      e = sb.pop_front();
      checks++;
      if ({ProgCtr, Running, Done} !== {e.pc, e.run, e.done}) begin
        failures++;
        $display("FAIL back_to_back[%0d]: got pc=%h run=%b done=%b, expected pc=%h run=%b done=%b",
                 i, ProgCtr, Running, Done, e.pc, e.run, e.done);
      end
    end
  endtask

`ifdef PC_CYCLE_COUNT_EN
  task automatic test_cycle_count();
    stim_t       s;
    exp_t        e;
    logic [15:0] exp_cnt[9];
    exp_cnt = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd6, 16'd0};
    drive('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0});
    @(posedge Clk); #1;                       // park in DONE
    add(1,0,0,0,0,10'h000,0, 10'h000,1,0);
    add(0,0,0,0,0,10'h000,0, 10'h001,1,0);
    add(0,0,1,0,0,10'h000,0, 10'h001,1,0);
    add(0,0,1,0,0,10'h000,0, 10'h001,1,0);
    add(0,0,0,0,0,10'h000,0, 10'h002,1,0);
    add(0,0,0,0,0,10'h000,0, 10'h003,1,0);
    add(0,1,0,0,0,10'h000,0, 10'h003,0,1);
    add(0,0,0,0,0,10'h000,0, 10'h003,0,1);
    add(1,0,0,0,0,10'h000,0, 10'h000,1,0);
    for (int i = 0; st_q.size() > 0; i++) begin
      s = st_q.pop_front();
      drive(s);
      @(posedge Clk); #1;
      e = sb.pop_front();
      checks++;
      if ({ProgCtr, Running, Done, CycleCount} !== {e.pc, e.run, e.done, exp_cnt[i]}) begin
        failures++;
        $display("FAIL cycle_count[%0d]: got pc=%h run=%b done=%b cnt=%0d, expected pc=%h run=%b done=%b cnt=%0d",
                 i, ProgCtr, Running, Done, CycleCount, e.pc, e.run, e.done, exp_cnt[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_seq_halt();
    test_branch();
    test_stall();
    test_async_reset();
    test_back_to_back();
`ifdef PC_CYCLE_COUNT_EN
    test_cycle_count();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/program_counter_ctrl.md
# program_counter_ctrl

Program counter and fetch sequencer for the single-cycle datapath. Holds the instruction address, advances it each cycle, and redirects it on a taken branch using the registered `Cond` flag produced by the ALU's SLT/SEQ operations. Provides start/halt control to the testbench: it sits directly downstream of the ALU's condition output and upstream of instruction memory.

## Interface
Parameters:
- `W`, default 10: program counter width; instruction memory depth is 2^W.
- `START_ADDR`, default 0: address loaded on reset and on every accepted start.

Ports:
- `Clk`  input  1  system clock; all state updates on the rising edge.
- `Reset`  input  1  asynchronous, active-high reset.
- `Start`  input  1  begin program execution; accepted in IDLE or DONE only.
- `Halt`  input  1  decoded halt instruction at the current `ProgCtr`.
- `Stall`  input  1  freeze the PC for this cycle.
- `BranchEn`  input  1  decoded branch instruction at the current `ProgCtr`.
- `BranchRel`  input  1  1 means relative branch (`ProgCtr + Target`); 0 means absolute branch (`Target`).
- `Target`  input  W  branch offset (two's complement) or absolute address.
- `Cond`  input  1  ALU condition flag: result of the most recent SLT/SEQ, already registered.
- `ProgCtr`  output  W  current instruction address (registered).
- `Running`  output  1  high while in RUN.
- `Done`  output  1  high while in DONE.

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE.
- IDLE: `ProgCtr` = `START_ADDR`. `Start` moves to RUN. `ProgCtr` stays at `START_ADDR`, so the first instruction is fetched in the first RUN cycle.
- RUN: next-PC is evaluated in this priority order:
  - `Stall`: hold `ProgCtr`. Halt, branch and increment are all suppressed.
  - `Halt`: go to DONE and hold `ProgCtr` at the halt address.
  - `BranchEn && Cond`:
    - `BranchRel` = 1: `ProgCtr` ← `ProgCtr + Target`, computed modulo 2^W (so a negative offset wraps).
    - `BranchRel` = 0: `ProgCtr` ← `Target`.
  - Otherwise (including `BranchEn` with `Cond` = 0): `ProgCtr` ← `ProgCtr + 1`. From 2^W−1 this wraps to 0.
- `Start` is ignored in RUN.
- DONE: hold `ProgCtr`. `Start` moves to RUN and reloads `ProgCtr` = `START_ADDR`. All other inputs are ignored.
- Offset of 0 with `BranchRel` = 1 and `Cond` = 1 is a self-loop. It is legal.
- `Halt` and `BranchEn` both high: `Halt` wins.

## Timing
- Reset values: `ProgCtr` = `START_ADDR`, `Running` = 0, `Done` = 0, state IDLE.
- Reset is asynchronous: outputs take their reset values immediately on assertion, including mid-RUN. Deassertion is synchronous to `Clk` by upstream convention.
- Latency of one cycle from inputs to the new `ProgCtr`. `Running` and `Done` are registered state decodes and change in the same edge as the state.
- `Cond` is consumed as presented. Because it is registered inside the ALU, a compare executed at PC n steers the branch at PC n+1 or later. No extra delay is added here.
- `Start` is a level, sampled each edge. Holding it high in DONE restarts every cycle it sees DONE.

## Configuration
- Macro `PC_CYCLE_COUNT_EN`.
- Defined: adds output `CycleCount` [15:0], with reset value 0.
  - Cleared to 0 on each accepted `Start`.
  - Increments on every RUN cycle, including stalled cycles.
  - Saturates at 16'hFFFF.
  - Holds its value in IDLE and DONE.
- Undefined: the port and counter are absent, and all other behaviour is identical.

## Test plan
- Reset, then `Start` for one cycle, no branches, `Halt` at PC 5 -> `ProgCtr` reads 0,0,1,2,3,4,5. `Done` = 1 from the following cycle, `ProgCtr` holds at 5, `Running` = 0.
- At PC 3, `BranchEn` = 1, `BranchRel` = 1, `Target` = 10'h3FE (−2), `Cond` = 1 -> next `ProgCtr` = 1. Same stimulus with `Cond` = 0 -> next `ProgCtr` = 4.
- At PC 7, absolute branch with `Target` = 10'h200 and `Cond` = 1 -> next PC 0x200. At PC 0x3FF with no branch -> next PC 0x000 (wrap).
- `Stall` held 3 cycles at PC 4 with `Halt` and `BranchEn` high -> PC stays 4 and state stays RUN. When `Stall` drops with `Halt` still high -> DONE with PC 4.
- `Reset` asserted between edges in RUN at PC 9 -> `ProgCtr` = 0 and `Running` = 0 immediately. `Start` in DONE -> RUN with PC 0.
- With `PC_CYCLE_COUNT_EN` defined: run 6 RUN cycles including 2 stalls, then halt -> `CycleCount` = 6 and held. Restart -> `CycleCount` = 0.
